// File: rtl/rs_issue_select_if.sv
// Bundles the signals between the reservation-station entries, the decoder,
// the execute stage and the issue-select block.
//   master : the environment (entries, decoder, execute) driving the block
//   slave  : rs_issue_select itself
// Signals:
//   squash, dispatch_valid, fu_ready    control inputs to the block
//   entry_busy, entry_ready             per-entry status
//   entry_packet                        per-entry held issue packet
//   wr_en, clear                        per-entry allocate / clear strobes
//   rs_full                             no free entry, dispatch must stall
//   is_valid, is_packet                 issue output slot to execute
interface rs_issue_select_if #(
   parameter int RS_LEN = 8,
   parameter int PKT_W  = 32
);
   logic                          squash;
   logic                          dispatch_valid;
   logic                          fu_ready;
   logic [RS_LEN-1:0]             entry_busy;
   logic [RS_LEN-1:0]             entry_ready;
   logic [RS_LEN-1:0][PKT_W-1:0]  entry_packet;
   logic [RS_LEN-1:0]             wr_en;
   logic [RS_LEN-1:0]             clear;
   logic                          rs_full;
   logic                          is_valid;
   logic [PKT_W-1:0]              is_packet;

   modport master (
      output squash, dispatch_valid, fu_ready, entry_busy, entry_ready, entry_packet,
      input  wr_en, clear, rs_full, is_valid, is_packet
   );

   modport slave (
      input  squash, dispatch_valid, fu_ready, entry_busy, entry_ready, entry_packet,
      output wr_en, clear, rs_full, is_valid, is_packet
   );
endinterface

// File: rtl/rs_issue_select.sv
// Control and issue stage around RS_LEN reservation-station entries.
// Allocates the lowest free entry for a dispatched instruction, picks one
// ready entry per cycle in round-robin order, clears it and registers its
// packet into a valid/ready output slot feeding execute. Squash flushes all
// busy entries and the output slot.
// Ports:
//   clock  single clock
//   reset  synchronous, active-high
//   bus    rs_issue_select_if.slave (dispatch, entry status, issue slot)
module rs_issue_select #(
   parameter int RS_LEN = 8,
   parameter int PKT_W  = 32,
   parameter int PTR_W  = $clog2(RS_LEN)
) (
   input  logic             clock,
   input  logic             reset,
   rs_issue_select_if.slave bus
);
   logic [PTR_W-1:0]  rr_ptr;
   logic              valid;
   logic [PKT_W-1:0]  packet;

   logic              full;
   logic [RS_LEN-1:0] cand;
   logic [RS_LEN-1:0] alloc;
   logic              free_found;
   logic [PTR_W-1:0]  idx;
   logic [PTR_W-1:0]  gidx;
   logic              found;
   logic              slot_free;
   logic              grant_en;
   logic [RS_LEN-1:0] wr_en;
   logic [RS_LEN-1:0] clr;

   assign full      = &bus.entry_busy;
   assign cand      = bus.entry_ready & bus.entry_busy;
   assign slot_free = !valid || bus.fu_ready;
   assign grant_en  = !reset && !bus.squash && slot_free && found;

   // Lowest-index free entry.
   always_comb begin
      alloc      = '0;
      free_found = 1'b0;
      for (int i = 0; i < RS_LEN; i++) begin
         if (!free_found && !bus.entry_busy[i]) begin
            alloc[i]   = 1'b1;
            free_found = 1'b1;
         end
      end
   end

   // Round-robin search starting at rr_ptr; RS_LEN is a power of two so the
   // pointer add wraps naturally.
   always_comb begin
      idx   = '0;
      gidx  = '0;
      found = 1'b0;
      for (int i = 0; i < RS_LEN; i++) begin
         idx = rr_ptr + PTR_W'(i);
         if (!found && cand[idx]) begin
            found = 1'b1;
            gidx  = idx;
         end
      end
   end

   // Strobes: squash flushes every busy entry and blocks allocation.
   always_comb begin
      wr_en = '0;
      clr   = '0;
      if (!reset) begin
         if (bus.squash) begin
            clr = bus.entry_busy;
         end else begin
            if (bus.dispatch_valid && !full) wr_en = alloc;
            if (grant_en) clr[gidx] = 1'b1;
         end
      end
   end

   // Output slot and round-robin pointer.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid  <= 1'b0;
         packet <= '0;
         rr_ptr <= '0;
      end else if (bus.squash) begin
         valid  <= 1'b0;
         rr_ptr <= '0;
      end else if (grant_en) begin
         valid  <= 1'b1;
         packet <= bus.entry_packet[gidx];
         rr_ptr <= gidx + PTR_W'(1);
      end else if (bus.fu_ready && valid) begin
         valid  <= 1'b0;
      end
   end

   assign bus.wr_en     = wr_en;
   assign bus.clear     = clr;
   assign bus.rs_full   = full;
   assign bus.is_valid  = valid;
   assign bus.is_packet = packet;
endmodule

// File: tb/tb_rs_issue_select.sv
// Self-checking bench for rs_issue_select: directed scenarios plus a random
// phase, all compared against a behavioural model of the issue rules.
module tb_rs_issue_select;
   localparam int N     = 8;
   localparam int PKT_W = 16;

   logic clock;
   logic reset;

   rs_issue_select_if #(.RS_LEN(N), .PKT_W(PKT_W)) bus ();

   rs_issue_select #(.RS_LEN(N), .PKT_W(PKT_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   // Model state
   int unsigned      m_ptr     = 0;
   bit               m_valid   = 1'b0;
   bit               m_pkt_chk = 1'b0;
   bit               m_known   = 1'b0;
   logic [PKT_W-1:0] m_pkt     = '0;
   logic [PKT_W-1:0] pk [N];

   // Current-cycle inputs and model expectations
   bit          c_rst, c_sq, c_dv, c_fr;
   logic [N-1:0] c_busy, c_ready;
   logic [N-1:0] e_wr, e_clr;
   bit          e_full, e_gnt;
   int          e_g;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_comb();
      int free_i;
      int j;
      free_i = -1;
      e_full = (c_busy == {N{1'b1}});
      for (int i = 0; i < N; i++)
         if (free_i < 0 && !c_busy[i]) free_i = i;
      e_wr = '0;
      if (!c_rst && !c_sq && c_dv && !e_full && free_i >= 0) e_wr = N'(1) << free_i;
      e_gnt = 1'b0;
      e_g   = 0;
      if (!c_rst && !c_sq && (!m_valid || c_fr)) begin
         for (int k = 0; k < N; k++) begin
            j = (int'(m_ptr) + k) % N;
            if (!e_gnt && c_busy[j] && c_ready[j]) begin
               e_gnt = 1'b1;
               e_g   = j;
            end
         end
      end
      if (c_rst)      e_clr = '0;
      else if (c_sq)  e_clr = c_busy;
      else if (e_gnt) e_clr = N'(1) << e_g;
      else            e_clr = '0;
   endtask

   // Apply inputs after the falling edge and check all outputs 1 time unit later.
   task automatic drive(input bit rst, input bit sq, input bit dv,
                        input logic [N-1:0] busy, input logic [N-1:0] ready, input bit fr);
      @(negedge clock);
      c_rst = rst; c_sq = sq; c_dv = dv; c_busy = busy; c_ready = ready; c_fr = fr;
      reset              = rst;
      bus.squash         = sq;
      bus.dispatch_valid = dv;
      bus.entry_busy     = busy;
      bus.entry_ready    = ready;
      bus.fu_ready       = fr;
      for (int i = 0; i < N; i++) begin
         pk[i] = PKT_W'($urandom);
         bus.entry_packet[i] = pk[i];
      end
      #1;
      model_comb();
      check_eq("wr_en", 64'(bus.wr_en), 64'(e_wr));
      check_eq("clear", 64'(bus.clear), 64'(e_clr));
      check_eq("rs_full", 64'(bus.rs_full), 64'(e_full));
      if (m_known) begin
         check_eq("is_valid", 64'(bus.is_valid), 64'(m_valid));
         if (m_pkt_chk) check_eq("is_packet", 64'(bus.is_packet), 64'(m_pkt));
      end
   endtask

   // Advance the model with the current inputs, then let the clock edge happen.
   task automatic tick();
      if (c_rst) begin
         m_valid = 1'b0; m_pkt = '0; m_pkt_chk = 1'b1; m_ptr = 0; m_known = 1'b1;
      end else if (c_sq) begin
         m_valid = 1'b0; m_ptr = 0; m_pkt_chk = 1'b0;
      end else if (e_gnt) begin
         m_valid = 1'b1; m_pkt = pk[e_g]; m_pkt_chk = 1'b1; m_ptr = (e_g + 1) % N;
      end else if (c_fr && m_valid) begin
         m_valid = 1'b0; m_pkt_chk = 1'b0;
      end
      @(posedge clock);
   endtask

   initial begin
      int exp_g [4];
      logic [PKT_W-1:0] saved;
      exp_g = '{0, 2, 7, 0};

      reset = 1'b1;
      bus.squash = 1'b0; bus.dispatch_valid = 1'b0; bus.fu_ready = 1'b0;
      bus.entry_busy = '0; bus.entry_ready = '0; bus.entry_packet = '0;

      // Initial reset
      drive(1, 0, 0, '0, '0, 0); tick();
      drive(1, 0, 0, '0, '0, 0); tick();

      // Allocation of lowest free entry
      drive(0, 0, 1, 8'h0B, 8'h00, 1);
      check_eq("alloc_0B", 64'(bus.wr_en), 64'h04);
      check_eq("full_0B", 64'(bus.rs_full), 64'h0);
      tick();

      // Full station blocks dispatch
      drive(0, 0, 1, 8'hFF, 8'h00, 0);
      check_eq("alloc_FF", 64'(bus.wr_en), 64'h00);
      check_eq("full_FF", 64'(bus.rs_full), 64'h1);
      tick();

      // Random phase
      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
               $urandom_range(0, 1), N'($urandom), N'($urandom),
               ($urandom_range(0, 9) < 7));
         tick();
      end

      // Reset held 2 cycles with inputs active
      for (int n = 0; n < 2; n++) begin
         drive(1, 1, 1, 8'h0F, 8'hFF, 1);
         check_eq("rst_wr_en", 64'(bus.wr_en), 64'h0);
         check_eq("rst_clear", 64'(bus.clear), 64'h0);
         tick();
      end
      drive(0, 0, 0, 8'h00, 8'h00, 0);
      check_eq("rst_is_valid", 64'(bus.is_valid), 64'h0);
      check_eq("rst_is_packet", 64'(bus.is_packet), 64'h0);
      tick();

      // Round robin over entries 0,2,7
      saved = '0;
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 0, 8'h85, 8'h85, 1);
         if (k > 0) check_eq("rr_packet", 64'(bus.is_packet), 64'(saved));
         check_eq("rr_clear", 64'(bus.clear), 64'(N'(1) << exp_g[k]));
         saved = pk[exp_g[k]];
         tick();
      end

      // Stall holds the slot
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 8'h02, 8'h02, 0);
         check_eq("stall_clear", 64'(bus.clear), 64'h0);
         check_eq("stall_packet", 64'(bus.is_packet), 64'(saved));
         check_eq("stall_valid", 64'(bus.is_valid), 64'h1);
         tick();
      end
      drive(0, 0, 0, 8'h02, 8'h02, 1);
      check_eq("unstall_clear", 64'(bus.clear), 64'h02);
      saved = pk[1];
      tick();

      // Squash during stall
      drive(0, 1, 1, 8'h3C, 8'h3C, 0);
      check_eq("sq_prev_packet", 64'(bus.is_packet), 64'(saved));
      check_eq("sq_clear", 64'(bus.clear), 64'h3C);
      check_eq("sq_wr_en", 64'(bus.wr_en), 64'h0);
      tick();
      drive(0, 0, 0, 8'hFF, 8'hFF, 1);
      check_eq("sq_is_valid", 64'(bus.is_valid), 64'h0);
      check_eq("sq_ptr_zero", 64'(bus.clear), 64'h01);
      tick();
      drive(0, 0, 0, 8'h00, 8'h00, 1);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
